matmul_mem_server: RTL

MATMUL_MEM_SERVER -- requirements
Module: matmul_mem_server

---
 rtl/matmul_mem_server_pkg.sv | 23 ++
 rtl/matmul_mem_server_memref_bank.sv | 44 ++++
 rtl/matmul_mem_server.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/matmul_mem_server_pkg.sv
// Shared types and defaults for the matmul memory server.
package matmul_mem_server_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned WR_COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_C    = 2'd2,
    SEL_NONE = 2'd3
  } host_sel_t;

endpackage

// File: rtl/matmul_mem_server_memref_bank.sv
// Single-write-port memory with one registered read port.
// Out-of-range writes are ignored and out-of-range reads return zero.
// Storage is never cleared by reset; only the read register is.
module memref_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_in_range;
  logic              r_in_range;

  assign w_in_range = ({1'b0, waddr} < LIMIT);
  assign r_in_range = ({1'b0, raddr} < LIMIT);

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; holds when re=0, so a same-cycle write yields old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= r_in_range ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/matmul_mem_server.sv
// Memory server for a matmul kernel: banks A/B (kernel read), bank C
// (kernel write), host access to all three, and a run-control FSM.
module matmul_mem_server
  import matmul_mem_server_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int EXP_WRITES = 256,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] v0_addr,
  input  logic              v0_rd_en,
  output logic [DATA_W-1:0] v0_rd_data,
  input  logic [ADDR_W-1:0] v1_addr,
  input  logic              v1_rd_en,
  output logic [DATA_W-1:0] v1_rd_data,
  input  logic [ADDR_W-1:0] v2_addr,
  input  logic              v2_wr_en,
  input  logic [DATA_W-1:0] v2_wr_data,
  output logic              tstart,
  input  logic [1:0]        host_sel,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W:0] LIMIT    = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     EXP_CNT  = 16'(EXP_WRITES);
  localparam logic [31:0]     TMO_LAST = 32'(TIMEOUT - 1);

  state_t            state;
  host_sel_t         sel_q;
  logic [31:0]       tmo_cnt;
  logic              kernel_owns_c;
  logic              v2_in_range;
  logic              v2_accept;
  logic              v2_reject;
  logic              host_wr_ok;
  logic              we_a;
  logic              we_b;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [15:0]       wr_inc;
  logic [DATA_W-1:0] a_host_rd;
  logic [DATA_W-1:0] b_host_rd;
  logic [DATA_W-1:0] c_host_rd;

  assign kernel_owns_c = (state == ST_LAUNCH) || (state == ST_RUN);
  assign v2_in_range   = ({1'b0, v2_addr} < LIMIT);
  // Writes landing on the reset edge are dropped along with the run.
  assign v2_accept     = v2_wr_en && kernel_owns_c && v2_in_range && !rst;
  assign v2_reject     = v2_wr_en && !(kernel_owns_c && v2_in_range);
  assign host_wr_ok    = host_we && !busy && !rst;
  assign we_a          = host_wr_ok && (host_sel == SEL_A);
  assign we_b          = host_wr_ok && (host_sel == SEL_B);
  assign wr_inc        = (wr_count == 16'hFFFF) ? wr_count : wr_count + 16'd1;

  // Bank C write port: kernel owns it while a run is active, host otherwise.
  always_comb begin
    c_we    = 1'b0;
    c_addr  = host_addr;
    c_wdata = host_wdata;
    if (kernel_owns_c) begin
      c_we    = v2_accept;
      c_addr  = v2_addr;
      c_wdata = v2_wr_data;
    end else begin
      c_we    = host_wr_ok && (host_sel == SEL_C);
    end
  end

  memref_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_a_k (
    .clk(clk), .rst(rst), .we(we_a), .waddr(host_addr), .wdata(host_wdata),
    .re(v0_rd_en), .raddr(v0_addr), .rdata(v0_rd_data)
  );

  memref_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_a_h (
    .clk(clk), .rst(rst), .we(we_a), .waddr(host_addr), .wdata(host_wdata),
    .re(1'b1), .raddr(host_addr), .rdata(a_host_rd)
  );

  memref_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_b_k (
    .clk(clk), .rst(rst), .we(we_b), .waddr(host_addr), .wdata(host_wdata),
    .re(v1_rd_en), .raddr(v1_addr), .rdata(v1_rd_data)
  );

  memref_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_b_h (
    .clk(clk), .rst(rst), .we(we_b), .waddr(host_addr), .wdata(host_wdata),
    .re(1'b1), .raddr(host_addr), .rdata(b_host_rd)
  );

  memref_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_c (
    .clk(clk), .rst(rst), .we(c_we), .waddr(c_addr), .wdata(c_wdata),
    .re(1'b1), .raddr(host_addr), .rdata(c_host_rd)
  );

  // Remember which bank the host addressed so the registered data lines up.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_NONE;
    end else begin
      sel_q <= host_sel_t'(host_sel);
    end
  end

  // Host read data: pick the bank addressed one cycle earlier.
  always_comb begin
    host_rdata = '0;
    case (sel_q)
      SEL_A:   host_rdata = a_host_rd;
      SEL_B:   host_rdata = b_host_rd;
      SEL_C:   host_rdata = c_host_rd;
      default: host_rdata = '0;
    endcase
  end

  // Run-control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tstart   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (v2_accept) wr_count <= wr_inc;
      if (v2_reject) err <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (host_start) begin
            state    <= ST_LAUNCH;
            tstart   <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            // A dropped write on the start edge is still reported.
            err      <= v2_reject;
            wr_count <= '0;
            tmo_cnt  <= '0;
          end
        end
        ST_LAUNCH: begin
          state  <= ST_RUN;
          tstart <= 1'b0;
        end
        ST_RUN: begin
          if (v2_accept && (wr_inc == EXP_CNT)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
